// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants for the fetch/PC front end: state encoding, reset PC and
// instruction field positions used by the next-PC logic.
package fetch_pc_unit_pkg;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    // Branch displacement: sign-extended word offset converted to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_next_pc_logic.sv
// Combinational next-PC selection: jr > j/jal > taken branch > sequential.
// Also flags a jr target that is not word aligned.
module next_pc_logic
    import fetch_pc_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4_i,
    input  logic [25:0]       instr_field_i,
    input  logic              jr_i,
    input  logic              jump_i,
    input  logic              branch_i,
    input  logic              branch_taken_i,
    input  logic [31:0]       rs_data_i,
    output logic [ADDR_W-1:0] next_pc_o,
    output logic              misalign_o
);

    logic [ADDR_W-1:0] jr_target;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_target;

    assign jr_target     = ADDR_W'({rs_data_i[31:2], 2'b00});
    assign jump_target   = {pc_plus4_i[ADDR_W-1:28], instr_field_i[TARGET_MSB:TARGET_LSB], 2'b00};
    assign branch_target = pc_plus4_i + ADDR_W'(branch_offset(instr_field_i[IMM_MSB:IMM_LSB]));

    always_comb begin
        next_pc_o  = pc_plus4_i;
        misalign_o = 1'b0;
        if (jr_i) begin
            next_pc_o  = jr_target;
            misalign_o = (rs_data_i[1:0] != 2'b00);
        end else if (jump_i) begin
            next_pc_o = jump_target;
        end else if (branch_i && branch_taken_i) begin
            next_pc_o = branch_target;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// MIPS fetch front end: BOOT -> FETCH (req/ack) -> EXEC (commit or stall),
// holding the PC and the captured instruction for the decoder.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_ack,
    input  logic [31:0]       im_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              commit,
    input  logic              stall,
    input  logic              Jump,
    input  logic              Branch,
    input  logic              Jr,
    input  logic              branch_taken,
    input  logic [31:0]       rs_data,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              addr_err
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              addr_err_q, addr_err_d;
    logic [ADDR_W-1:0] next_pc;
    logic              misalign;

    next_pc_logic #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc_plus4_i     (pc_plus4),
        .instr_field_i  (instr_q[TARGET_MSB:TARGET_LSB]),
        .jr_i           (Jr),
        .jump_i         (Jump),
        .branch_i       (Branch),
        .branch_taken_i (branch_taken),
        .rs_data_i      (rs_data),
        .next_pc_o      (next_pc),
        .misalign_o     (misalign)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        addr_err_d = addr_err_q;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                if (im_ack) begin
                    instr_d = im_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // The misalign flag latches only when the jr actually retires.
                if (!stall) begin
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
                    if (misalign) begin
                        addr_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign im_req      = (state_q == ST_FETCH);
    assign instr_valid = (state_q == ST_EXEC);
    assign commit      = instr_valid && !stall;
    assign im_addr     = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + ADDR_W'(4);
    assign instr       = instr_q;
    assign addr_err    = addr_err_q;

endmodule
